nvram_upload_server: RTL and testbench

- Serves the HPS side of an ioctl upload session, supplying bytes from a core-side RAM such as hiscore or NVRAM through a read-intent port.
- Requests a CPU pause and holds ioctl_wait until the RAM is safe to read, then answers each ioctl_rd with one byte.
- Can also request an upload on demand through a save trigger.
- Sits beside hps_io and the pause block in the top level, and is the read/upload counterpart to the download/write path.

---
 rtl/nvram_upload_server.sv | 157 +++++++++++++++
 tb/tb_nvram_upload_server.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload_server.sv
// Upload-side ioctl server: pauses the CPU, waits for the pause to settle, then
// answers each HPS byte read from a core RAM through a read-intent port.
module nvram_upload_server #(
  parameter int         ADDR_W       = 10,
  parameter int         RAM_LATENCY  = 1,
  parameter logic [7:0] UPLOAD_INDEX = 8'd4,
  parameter int         PAUSE_SETTLE = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              save_trigger,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  input  logic [ADDR_W:0]   image_len,
  input  logic              paused,
  input  logic [7:0]        ram_data,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  output logic              pause_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_intent_read,
  output logic              busy
);

  // Handshake: ioctl_rd is a one-cycle strobe accepted only in ACTIVE while
  // ioctl_wait is low; the byte is on ioctl_din the cycle ioctl_wait is low again.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_FETCH  = 3'd4;

  localparam int                  SETTLE_W    = $clog2(PAUSE_SETTLE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(PAUSE_SETTLE - 1);
  localparam logic [2:0]          LAT_LAST    = 3'(RAM_LATENCY);

  logic [2:0]          state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [2:0]          lat_cnt;
  logic [ADDR_W:0]     len_q;
  logic                pend;
  logic [24:0]         pend_addr;
  logic                session_start;
  logic                rd_in_range;
  logic                pend_in_range;

  assign session_start = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  // Full 25-bit compare so high addresses never alias into the RAM.
  assign rd_in_range   = ioctl_addr < 25'(len_q);
  assign pend_in_range = pend_addr < 25'(len_q);
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state            <= S_IDLE;
      settle_cnt       <= '0;
      lat_cnt          <= '0;
      len_q            <= '0;
      pend             <= 1'b0;
      pend_addr        <= '0;
      ioctl_din        <= 8'h00;
      ioctl_wait       <= 1'b0;
      ioctl_upload_req <= 1'b0;
      pause_req        <= 1'b0;
      ram_addr         <= '0;
      ram_intent_read  <= 1'b0;
    end else begin
      ioctl_upload_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (session_start) begin
            state      <= S_SETTLE;
            len_q      <= image_len;
            pause_req  <= 1'b1;
            ioctl_wait <= 1'b1;
            settle_cnt <= '0;
            pend       <= 1'b0;
          end else if (save_trigger) begin
            state            <= S_REQ;
            ioctl_upload_req <= 1'b1;
          end
        end
        S_REQ: state <= S_IDLE;
        default: begin
          if (!ioctl_upload) begin
            // Session ended by the HPS: release everything, keep the last byte.
            state           <= S_IDLE;
            pause_req       <= 1'b0;
            ioctl_wait      <= 1'b0;
            ram_intent_read <= 1'b0;
            pend            <= 1'b0;
            settle_cnt      <= '0;
            lat_cnt         <= '0;
          end else begin
            case (state)
              S_SETTLE: begin
                if (!paused) begin
                  settle_cnt <= '0;
                end else if (settle_cnt != SETTLE_LAST) begin
                  settle_cnt <= settle_cnt + SETTLE_W'(1);
                end else begin
                  settle_cnt <= '0;
                  pend       <= 1'b0;
                  if (pend && pend_in_range) begin
                    // A read arrived while unpaused; replay it now.
                    state           <= S_FETCH;
                    ram_addr        <= pend_addr[ADDR_W-1:0];
                    ram_intent_read <= 1'b1;
                    lat_cnt         <= '0;
                  end else begin
                    state      <= S_ACTIVE;
                    ioctl_wait <= 1'b0;
                    if (pend) ioctl_din <= 8'hFF;
                  end
                end
              end
              S_ACTIVE: begin
                if (ioctl_rd) begin
                  if (!paused) begin
                    state      <= S_SETTLE;
                    ioctl_wait <= 1'b1;
                    settle_cnt <= '0;
                    pend       <= 1'b1;
                    pend_addr  <= ioctl_addr;
                  end else if (rd_in_range) begin
                    state           <= S_FETCH;
                    ram_addr        <= ioctl_addr[ADDR_W-1:0];
                    ram_intent_read <= 1'b1;
                    ioctl_wait      <= 1'b1;
                    lat_cnt         <= '0;
                  end else begin
                    ioctl_din <= 8'hFF;
                  end
                end
              end
              S_FETCH: begin
                if (lat_cnt == LAT_LAST) begin
                  state           <= S_ACTIVE;
                  ioctl_din       <= ram_data;
                  ioctl_wait      <= 1'b0;
                  ram_intent_read <= 1'b0;
                end else begin
                  lat_cnt <= lat_cnt + 3'd1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_upload_server.sv
// Bench for nvram_upload_server: random RAM image, sessions with random lengths
// and addresses, checked against a byte-level model of what the HPS should see.
module tb_nvram_upload_server;

  localparam int         AW  = 10;
  localparam int         LAT = 2;
  localparam int         PS  = 4;
  localparam logic [7:0] IDX = 8'd4;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              save_trigger;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [AW:0]       image_len;
  logic              paused;
  logic [7:0]        ram_data;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              ioctl_upload_req;
  logic              pause_req;
  logic [AW-1:0]     ram_addr;
  logic              ram_intent_read;
  logic              busy;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] ram_p1;
  int         cur_len;

  nvram_upload_server #(
    .ADDR_W(AW), .RAM_LATENCY(LAT), .UPLOAD_INDEX(IDX), .PAUSE_SETTLE(PS)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .save_trigger(save_trigger),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .image_len(image_len), .paused(paused),
    .ram_data(ram_data), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .pause_req(pause_req),
    .ram_addr(ram_addr), .ram_intent_read(ram_intent_read), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM with a two-cycle read latency
  always @(posedge clk_sys) begin
    ram_p1   <= mem[ram_addr];
    ram_data <= ram_p1;
  end

  function automatic logic [7:0] exp_byte(input logic [24:0] a, input int len);
    return (a < 25'(len)) ? mem[a[AW-1:0]] : 8'hFF;
  endfunction

  // Caller is at a negedge; returns at the negedge where ioctl_wait is low.
  task automatic do_read(input logic [24:0] a, output logic [7:0] d, output int wc,
                         output logic intent_seen, output logic [AW-1:0] addr_seen);
    ioctl_rd = 1'b1; ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    wc = 0; intent_seen = 1'b0; addr_seen = '0;
    while (ioctl_wait && wc < 100) begin
      if (ram_intent_read) begin intent_seen = 1'b1; addr_seen = ram_addr; end
      wc++;
      @(negedge clk_sys);
    end
    if (ram_intent_read) intent_seen = 1'b1;
    d = ioctl_din;
  endtask

  task automatic start_session(input int len);
    ioctl_upload = 1'b1; ioctl_index = IDX; image_len = (AW+1)'(len); paused = 1'b0;
    cur_len = len;
    @(negedge clk_sys);
  endtask

  task automatic settle(output int n);
    paused = 1'b1; n = 0;
    do begin @(negedge clk_sys); n++; end while (ioctl_wait && n < 100);
  endtask

  task automatic end_session;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_reset;
    reset = 1'b1; save_trigger = 0; ioctl_upload = 0; ioctl_index = 0; ioctl_rd = 0;
    ioctl_addr = 0; image_len = 0; paused = 0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({ioctl_din, ioctl_wait, ioctl_upload_req, pause_req, ram_addr, ram_intent_read, busy} !== '0) begin
      fails++; $display("FAIL reset_outputs: din=%h wait=%b req=%b pause=%b addr=%h intent=%b busy=%b expected all 0",
        ioctl_din, ioctl_wait, ioctl_upload_req, pause_req, ram_addr, ram_intent_read, busy);
    end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_save_trigger;
    save_trigger = 1'b1;
    @(negedge clk_sys);
    save_trigger = 1'b0;
    checks++;
    if ({ioctl_upload_req, busy} !== 2'b11) begin
      fails++; $display("FAIL trigger_pulse: req=%b busy=%b expected 1 1", ioctl_upload_req, busy);
    end
    @(negedge clk_sys);
    checks++;
    if ({ioctl_upload_req, busy} !== 2'b00) begin
      fails++; $display("FAIL trigger_one_cycle: req=%b busy=%b expected 0 0", ioctl_upload_req, busy);
    end
    // trigger together with a matching session: session wins
    save_trigger = 1'b1;
    start_session(16);
    save_trigger = 1'b0;
    checks++;
    if ({ioctl_upload_req, busy, ioctl_wait, pause_req} !== 4'b0111) begin
      fails++; $display("FAIL trigger_vs_session: req=%b busy=%b wait=%b pause=%b expected 0 1 1 1",
        ioctl_upload_req, busy, ioctl_wait, pause_req);
    end
    end_session();
    checks++;
    if ({busy, ioctl_wait, pause_req} !== 3'b000) begin
      fails++; $display("FAIL settle_abort: busy=%b wait=%b pause=%b expected 0 0 0", busy, ioctl_wait, pause_req);
    end
  endtask

  task automatic test_nonmatch;
    int bad;
    bad = 0;
    ioctl_upload = 1'b1; ioctl_index = 8'd3; image_len = 11'd16;
    repeat (3) begin
      @(negedge clk_sys);
      if (busy || pause_req || ioctl_wait) bad++;
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL nonmatch_idle: active cycles=%0d expected 0", bad); end
    save_trigger = 1'b1;
    @(negedge clk_sys);
    save_trigger = 1'b0;
    checks++;
    if (ioctl_upload_req !== 1'b1) begin
      fails++; $display("FAIL nonmatch_trigger: req=%b expected 1", ioctl_upload_req);
    end
    end_session();
  endtask

  task automatic test_settle;
    int n, bad, g;
    bad = 0;
    start_session(16);
    repeat (2) begin
      if (!ioctl_wait || !pause_req) bad++;
      @(negedge clk_sys);
    end
    // a short paused burst below the settle count must restart the count
    g = $urandom_range(1, PS-1);
    paused = 1'b1;
    repeat (g) begin @(negedge clk_sys); if (!ioctl_wait || !pause_req) bad++; end
    paused = 1'b0;
    @(negedge clk_sys);
    if (!ioctl_wait) bad++;
    checks++;
    if (bad != 0) begin fails++; $display("FAIL settle_wait_held: bad cycles=%0d expected 0", bad); end
    settle(n);
    checks++;
    if (n != PS) begin fails++; $display("FAIL settle_count: wait fell after %0d paused cycles expected %0d", n, PS); end
    checks++;
    if ({pause_req, busy} !== 2'b11) begin
      fails++; $display("FAIL settle_active: pause=%b busy=%b expected 1 1", pause_req, busy);
    end
  endtask

  task automatic test_fetch;
    logic [7:0] d; int wc; logic it; logic [AW-1:0] ra;
    do_read(25'd0, d, wc, it, ra);
    checks++;
    if (d !== 8'h5A || wc != LAT+1 || it !== 1'b1 || ra !== 10'd0) begin
      fails++; $display("FAIL fetch_addr0: din=%h wait=%0d intent=%b addr=%0d expected 5a %0d 1 0", d, wc, it, ra, LAT+1);
    end
    do_read(25'd15, d, wc, it, ra);
    checks++;
    if (d !== 8'hC3 || wc != LAT+1 || it !== 1'b1 || ra !== 10'd15) begin
      fails++; $display("FAIL fetch_addr15: din=%h wait=%0d intent=%b addr=%0d expected c3 %0d 1 15", d, wc, it, ra, LAT+1);
    end
    checks++;
    if (ram_intent_read !== 1'b0 || pause_req !== 1'b1) begin
      fails++; $display("FAIL fetch_release: intent=%b pause=%b expected 0 1", ram_intent_read, pause_req);
    end
  endtask

  task automatic test_out_of_range;
    logic [7:0] d; int wc; logic it; logic [AW-1:0] ra;
    logic [24:0] addrs [2];
    addrs[0] = 25'd16; addrs[1] = 25'h100000;
    for (int i = 0; i < 2; i++) begin
      do_read(addrs[i], d, wc, it, ra);
      checks++;
      if (d !== 8'hFF || wc != 0 || it !== 1'b0) begin
        fails++; $display("FAIL oor_%0h: din=%h wait=%0d intent=%b expected ff 0 0", addrs[i], d, wc, it);
      end
    end
  endtask

  task automatic test_back_to_back;
    int wc;
    logic [24:0] a, b;
    a = 25'($urandom_range(0, 15)); b = 25'($urandom_range(0, 15));
    ioctl_rd = 1'b1; ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 1'b1; ioctl_addr = b;   // illegal strobe during wait
    wc = 0;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    wc = 1;
    while (ioctl_wait && wc < 100) begin wc++; @(negedge clk_sys); end
    checks++;
    if (ioctl_din !== exp_byte(a, cur_len) || wc != LAT+1) begin
      fails++; $display("FAIL rd_during_wait: din=%h wait=%0d expected %h %0d", ioctl_din, wc, exp_byte(a, cur_len), LAT+1);
    end
    checks++;
    if (ioctl_wait !== 1'b0 || ram_intent_read !== 1'b0) begin
      fails++; $display("FAIL rd_during_wait_idle: wait=%b intent=%b expected 0 0", ioctl_wait, ram_intent_read);
    end
  endtask

  task automatic test_pause_drop;
    int d, n, exp_n;
    d = $urandom_range(1, 3);
    paused = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'd3;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 100) begin
      n++;
      if (n == d) paused = 1'b1;
      @(negedge clk_sys);
    end
    // unpaused cycles after the strobe + settle window + fetch
    exp_n = (d - 1) + PS + (LAT + 1);
    checks++;
    if (n != exp_n || ioctl_din !== mem[3]) begin
      fails++; $display("FAIL pause_drop_retry: wait=%0d din=%h expected %0d %h", n, ioctl_din, exp_n, mem[3]);
    end
  endtask

  task automatic test_upload_drop;
    logic [7:0] prev;
    prev = ioctl_din;
    ioctl_rd = 1'b1; ioctl_addr = 25'd7;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({pause_req, ioctl_wait, ram_intent_read, busy} !== 4'b0000 || ioctl_din !== prev) begin
      fails++; $display("FAIL upload_drop: pause=%b wait=%b intent=%b busy=%b din=%h expected 0 0 0 0 %h",
        pause_req, ioctl_wait, ram_intent_read, busy, ioctl_din, prev);
    end
  endtask

  task automatic test_random;
    logic [7:0] d; int wc, n; logic it; logic [AW-1:0] ra;
    int lens [3];
    logic [24:0] a;
    lens[0] = 0; lens[1] = 1 << AW; lens[2] = $urandom_range(1, (1 << AW) - 1);
    for (int s = 0; s < 3; s++) begin
      start_session(lens[s]);
      settle(n);
      checks++;
      if (n != PS) begin fails++; $display("FAIL rand_settle_%0d: %0d expected %0d", s, n, PS); end
      for (int k = 0; k < 10; k++) begin
        case (k)
          0: a = 25'(lens[s]);
          1: a = 25'(lens[s]) - 25'd1;
          2: a = 25'($urandom_range(0, 25'h1FFFFFF));
          default: a = 25'($urandom_range(0, (1 << AW) + 64));
        endcase
        if (k == 1 && lens[s] == 0) a = 25'd0;
        do_read(a, d, wc, it, ra);
        checks++;
        if (d !== exp_byte(a, lens[s]) || wc != ((a < 25'(lens[s])) ? LAT+1 : 0)) begin
          fails++; $display("FAIL rand_read len=%0d addr=%0h: din=%h wait=%0d expected %h", lens[s], a, d, wc, exp_byte(a, lens[s]));
        end
      end
      end_session();
    end
  endtask

  task automatic test_reset_mid_fetch;
    int n;
    start_session(16);
    settle(n);
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    reset = 1'b1; ioctl_upload = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({ioctl_din, ioctl_wait, ioctl_upload_req, pause_req, ram_addr, ram_intent_read, busy} !== '0) begin
      fails++; $display("FAIL reset_mid_fetch: din=%h wait=%b pause=%b addr=%h intent=%b busy=%b expected all 0",
        ioctl_din, ioctl_wait, pause_req, ram_addr, ram_intent_read, busy);
    end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    mem[0] = 8'h5A; mem[15] = 8'hC3;
    test_reset();
    test_save_trigger();
    test_nonmatch();
    test_settle();
    test_fetch();
    test_out_of_range();
    test_back_to_back();
    test_pause_drop();
    test_upload_drop();
    test_random();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
